// File: rtl/stack_dt.sv
// Register-file LIFO operand stack with combinational top-of-stack read.
// Optional sticky misuse flag is built when STACK_ERR_EN is defined.
`ifndef SC_N
`define SC_N 2
`endif
`ifndef SC_NON
`define SC_NON 2'b00
`endif
`ifndef SC_PUS
`define SC_PUS 2'b01
`endif
`ifndef SC_POP
`define SC_POP 2'b10
`endif
`ifndef CD_N
`define CD_N 16
`endif
`ifndef CD_0
`define CD_0 16'd0
`endif

module stack_dt #(
   parameter int AW    = 4,
   parameter int DEPTH = 2**AW
) (
   input  logic             Clock,
   input  logic             Reset,
   input  logic [`SC_N-1:0] cmd,
   input  logic [`CD_N-1:0] d,
   output logic [`CD_N-1:0] q,
   output logic             empty,
   output logic             full,
   output logic [AW:0]      count,
   output logic             err
);

   logic [`CD_N-1:0] mem_q [DEPTH];
   logic [AW:0]      sp_q, sp_d;
   logic [AW-1:0]    rd_idx, wr_idx;
   logic             push_ok, pop_ok, misuse;

   assign empty  = (sp_q == '0);
   assign full   = (sp_q == (AW+1)'(DEPTH));
   assign count  = sp_q;
   assign rd_idx = AW'(sp_q - 1'b1);
   assign wr_idx = sp_q[AW-1:0];
   assign q      = empty ? `CD_0 : mem_q[rd_idx];

   always_comb begin
      push_ok = 1'b0;
      pop_ok  = 1'b0;
      misuse  = 1'b0;
      sp_d    = sp_q;
      unique case (cmd)
         `SC_PUS: begin
            push_ok = !full;
            misuse  = full;
         end
         `SC_POP: begin
            pop_ok = !empty;
            misuse = empty;
         end
         default: ;
      endcase
      if (push_ok)
         sp_d = sp_q + 1'b1;
      else if (pop_ok)
         sp_d = sp_q - 1'b1;
   end

   always_ff @(posedge Clock) begin
      if (Reset)
         sp_q <= '0;
      else
         sp_q <= sp_d;
   end

   // Entries are never cleared; q masks stale data when empty.
   always_ff @(posedge Clock) begin
      if (!Reset && push_ok)
         mem_q[wr_idx] <= d;
   end

`ifdef STACK_ERR_EN
   logic err_q, err_d;

   always_comb begin
      err_d = err_q | misuse;
   end

   always_ff @(posedge Clock) begin
      if (Reset)
         err_q <= 1'b0;
      else
         err_q <= err_d;
   end

   assign err = err_q;
`else
   logic unused_misuse;
   assign unused_misuse = misuse;
   assign err = 1'b0;
`endif

endmodule

// File: tb/tb_stack_dt.sv
// Scoreboard bench for stack_dt: driver queues expected state per cycle,
// a negedge monitor pops and compares.
`ifndef SC_N
`define SC_N 2
`endif
`ifndef SC_NON
`define SC_NON 2'b00
`endif
`ifndef SC_PUS
`define SC_PUS 2'b01
`endif
`ifndef SC_POP
`define SC_POP 2'b10
`endif
`ifndef CD_N
`define CD_N 16
`endif
`ifndef CD_0
`define CD_0 16'd0
`endif

module tb_stack_dt;

   localparam int AW = 4;
   localparam int DEPTH = 16;
`ifdef STACK_ERR_EN
   localparam bit ERR_EN = 1'b1;
`else
   localparam bit ERR_EN = 1'b0;
`endif

   logic             Clock = 1'b0;
   logic             Reset = 1'b1;
   logic [`SC_N-1:0] cmd   = `SC_NON;
   logic [`CD_N-1:0] d     = '0;
   logic [`CD_N-1:0] q;
   logic             empty, full, err;
   logic [AW:0]      count;

   stack_dt #(.AW(AW), .DEPTH(DEPTH)) dut (
      .Clock(Clock), .Reset(Reset), .cmd(cmd), .d(d),
      .q(q), .empty(empty), .full(full), .count(count), .err(err)
   );

   always #5 Clock = ~Clock;

   typedef struct {
      int          cyc;
      logic [15:0] q;
      int          cnt;
      bit          emp;
      bit          ful;
      bit          er;
   } exp_t;

   exp_t sb[$];
   int   cyc = 0;
   int   checks = 0;
   int   errors = 0;

   always @(posedge Clock) cyc <= cyc + 1;

   task automatic cmp(string nm, int act, int req);
      checks++;
      if (act != req) begin
         errors++;
         $display("FAIL %s cyc=%0d actual=%0d required=%0d", nm, cyc, act, req);
      end
   endtask

   always @(negedge Clock) begin
      while (sb.size() > 0 && sb[0].cyc <= cyc) begin
         exp_t e;
         e = sb.pop_front();
         if (e.cyc < cyc) begin
            checks++;
            errors++;
            $display("FAIL stale_entry cyc=%0d actual=%0d required=%0d", cyc, cyc, e.cyc);
         end else begin
            cmp("q", int'(q), int'(e.q));
            cmp("count", int'(count), e.cnt);
            cmp("empty", int'(empty), int'(e.emp));
            cmp("full", int'(full), int'(e.ful));
            cmp("err", int'(err), int'(e.er));
         end
      end
   end

   task automatic tick(input logic [`SC_N-1:0] c, input int dd, input bit rst = 1'b0);
      @(posedge Clock);
      #1;
      Reset = rst;
      cmd   = c;
      d     = 16'(dd);
   endtask

   task automatic expect_now(input int qv, input int cnt, input bit er);
      exp_t e;
      e.cyc = cyc;
      e.q   = 16'(qv);
      e.cnt = cnt;
      e.emp = (cnt == 0);
      e.ful = (cnt == DEPTH);
      e.er  = er;
      sb.push_back(e);
   endtask

   initial begin
      // reset then idle
      tick(`SC_NON, 0, 1'b1);
      tick(`SC_NON, 0);
      expect_now(0, 0, 1'b0);
      for (int i = 0; i < 5; i++) begin
         tick(`SC_NON, 0);
         expect_now(0, 0, 1'b0);
      end

      // LIFO order
      tick(`SC_PUS, 3);
      tick(`SC_PUS, 7);
      tick(`SC_PUS, 9);
      tick(`SC_POP, 0); expect_now(9, 3, 1'b0);
      tick(`SC_POP, 0); expect_now(7, 2, 1'b0);
      tick(`SC_POP, 0); expect_now(3, 1, 1'b0);
      tick(`SC_NON, 0); expect_now(0, 0, 1'b0);

      // full boundary
      for (int i = 1; i <= 16; i++) tick(`SC_PUS, i);
      tick(`SC_NON, 0); expect_now(16, 16, 1'b0);
      tick(`SC_PUS, 99);
      tick(`SC_NON, 0); expect_now(16, 16, ERR_EN);
      for (int i = 16; i >= 1; i--) begin
         tick(`SC_POP, 0);
         expect_now(i, i, ERR_EN);
      end
      tick(`SC_NON, 0); expect_now(0, 0, ERR_EN);

      // empty boundary
      tick(`SC_NON, 0, 1'b1);
      tick(`SC_NON, 0); expect_now(0, 0, 1'b0);
      tick(`SC_POP, 0); expect_now(0, 0, 1'b0);
      tick(`SC_NON, 0); expect_now(0, 0, ERR_EN);
      tick(`SC_PUS, 5);
      tick(`SC_NON, 0); expect_now(5, 1, ERR_EN);

      // reset mid-operation, colliding with a push
      tick(`SC_NON, 0, 1'b1);
      tick(`SC_PUS, 4);
      tick(`SC_PUS, 8);
      tick(`SC_PUS, 6, 1'b1);
      tick(`SC_NON, 0); expect_now(0, 0, 1'b0);
      tick(`SC_PUS, 2);
      tick(`SC_NON, 0); expect_now(2, 1, 1'b0);

      // unknown command on [1, 2]
      tick(`SC_NON, 0, 1'b1);
      tick(`SC_PUS, 1);
      tick(`SC_PUS, 2);
      tick(2'b11, 77); expect_now(2, 2, 1'b0);
      tick(`SC_NON, 0); expect_now(2, 2, 1'b0);

      tick(`SC_NON, 0);
      tick(`SC_NON, 0);
      checks++;
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_drain actual=%0d required=0", sb.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/stack_dt.md
# stack_dt

Data (operand) stack of the calculator controller. Stores `CD_N-wide numbers pushed and popped by the controller's memory stage, which issues one stack command per cycle. Implemented as a register-file LIFO with an up/down stack pointer. The top of stack is readable combinationally, so a value popped in a controller state is usable in that same cycle. Empty and full flags feed the controller's next-state logic.

## Interface
Parameters:
- AW, 4, pointer width; DEPTH = 2**AW entries.
- DEPTH, 16, number of entries; must equal 2**AW.

Ports:
- Clock  in  1  system clock; all state updates on rising edge.
- Reset  in  1  synchronous, active-high reset; one clock; takes priority over every command.
- cmd  in  `SC_N  stack command: `SC_NON, `SC_PUS, `SC_POP from STACK_INTERFACE.v; any other code is treated as `SC_NON.
- d  in  `CD_N  push data; sampled only when cmd == `SC_PUS.
- q  out  `CD_N  top-of-stack value, combinational from stored state; `CD_0 when empty.
- empty  out  1  high when count == 0.
- full  out  1  high when count == DEPTH.
- count  out  AW+1  number of stored entries, 0..DEPTH.
- err  out  1  sticky misuse flag (see Configuration).

## Operation
- State: entry array mem[0..DEPTH-1], pointer sp (AW+1 bits) = count; the top entry is mem[sp-1].
- `SC_PUS, not full: mem[sp] <= d; sp <= sp+1.
- `SC_POP, not empty: sp <= sp-1. mem is not cleared, and q shows the popped value during the pop cycle.
- `SC_NON or an unknown code: no state change.
- Push when full: ignored; sp and mem are unchanged, and no write wraps to mem[0].
- Pop when empty: ignored; sp stays 0 and never wraps to DEPTH.
- Only one command per cycle is possible. No simultaneous push/pop exists.
- Reset: sp <= 0 and err <= 0. mem contents are don't-care, because q is forced to `CD_0 when empty.
- Outputs are a pure function of registered state: q = empty ? `CD_0 : mem[sp-1]; empty = (sp == 0); full = (sp == DEPTH); count = sp.

## Timing
- Reset values: q = `CD_0, empty = 1, full = 0, count = 0, err = 0, visible in the cycle after the reset edge.
- Push latency: the value pushed at edge N appears on q, and count increments, after edge N.
- Pop: q holds the value being popped throughout the cycle in which cmd == `SC_POP. After the edge, q shows the new top, or `CD_0 if the stack is now empty.
- Reset asserted in the same cycle as a push or pop: reset wins, and the command is lost.
- No handshake. The caller must check empty/full before issuing a command. Misuse is absorbed as specified above.

## Configuration
- Macro STACK_ERR_EN.
- Defined: err is set on any clock edge where a push arrives while full or a pop arrives while empty. It stays set until Reset. The offending command is still ignored.
- Undefined: err is tied to 1'b0, and no error register is synthesized. Stack behaviour is otherwise identical.

## Test plan
- Reset then idle: after Reset high for 1 cycle, expect empty = 1, count = 0, q = `CD_0, err = 0. Hold `SC_NON for 5 cycles; expect no change.
- LIFO order: push 3, 7, 9 on consecutive cycles, then pop 3 times. During the pop cycles expect q = 9, 7, 3. Afterwards expect empty = 1 and q = `CD_0.
- Full boundary: push 1..16. Expect full = 1, count = 16, q = 16. Push 99; expect count = 16, q = 16, and err = 1 with STACK_ERR_EN (0 without). Pop 16 times; expect the values 16..1 in order.
- Empty boundary: pop on an empty stack. Expect count = 0, empty = 1, q = `CD_0; err = 1 only with STACK_ERR_EN. Then push 5; expect q = 5, count = 1.
- Reset mid-operation: push 4 and 8, then assert Reset in the same cycle as push 6. Expect count = 0, empty = 1, err = 0. Then push 2; expect q = 2.
- Unknown command: drive an unused cmd code with d = 77 on a stack holding [1, 2]. Expect q = 2, count = 2, no change.
